fp_decode_align: RTL and testbench

Parametrised two-stage, valid/ready-handshaked front end of the floating-point adder. Per operation it unpacks two IEEE-754-style operands, classifies specials, orders the pair by magnitude, and right-aligns the smaller significand with guard/round/sticky bits. Its output feeds the significand add/subtract stage directly. It adds denormal handling, subtraction mode, special-value detection and backpressure to the single-cycle decode stage.

---
 rtl/fp_decode_align.sv | 169 ++++++++++++++++
 tb/tb_fp_decode_align.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fp_decode_align.sv
// Two-stage front end of the FP adder: unpack, classify, magnitude-order and align operands.
// Stage 1 registers the decoded/ordered pair, stage 2 registers the aligned significands.
module fp_decode_align #(
  parameter int unsigned E_WIDTH = 8,
  parameter int unsigned M_WIDTH = 23
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [E_WIDTH+M_WIDTH:0]   i_a,
  input  logic [E_WIDTH+M_WIDTH:0]   i_b,
  input  logic                       i_op_sub,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic                       o_sign_l,
  output logic                       o_sign_s,
  output logic [E_WIDTH-1:0]         o_exp_l,
  output logic [E_WIDTH-1:0]         o_exp_diff,
  output logic [M_WIDTH+3:0]         o_mnt_l,
  output logic [M_WIDTH+3:0]         o_mnt_s_al,
  output logic                       o_swapped,
  output logic                       o_eff_sub,
  output logic [1:0]                 o_special
);

  localparam int unsigned W = M_WIDTH + 4;
  localparam int unsigned N = E_WIDTH + M_WIDTH + 1;

  localparam logic [1:0] SP_NORMAL = 2'b00;
  localparam logic [1:0] SP_ZERO   = 2'b01;
  localparam logic [1:0] SP_INF    = 2'b10;
  localparam logic [1:0] SP_NAN    = 2'b11;

  // ---------------- Stage 1 combinational decode ----------------
  logic               w_sign_a, w_sign_b;
  logic [E_WIDTH-1:0] w_exp_a, w_exp_b, w_eexp_a, w_eexp_b;
  logic [M_WIDTH-1:0] w_mnt_a, w_mnt_b;
  logic               w_hid_a, w_hid_b;
  logic [W-1:0]       w_sig_a, w_sig_b;
  logic               w_b_gt;
  logic               w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic [1:0]         w_special;

  assign w_sign_a = i_a[N-1];
  assign w_sign_b = i_b[N-1] ^ i_op_sub;
  assign w_exp_a  = i_a[N-2 -: E_WIDTH];
  assign w_exp_b  = i_b[N-2 -: E_WIDTH];
  assign w_mnt_a  = i_a[M_WIDTH-1:0];
  assign w_mnt_b  = i_b[M_WIDTH-1:0];

  // Zero/denormal operands behave as exponent 1 with no hidden bit.
  assign w_hid_a  = |w_exp_a;
  assign w_hid_b  = |w_exp_b;
  assign w_eexp_a = w_hid_a ? w_exp_a : E_WIDTH'(1);
  assign w_eexp_b = w_hid_b ? w_exp_b : E_WIDTH'(1);
  assign w_sig_a  = {w_hid_a, w_mnt_a, 3'b000};
  assign w_sig_b  = {w_hid_b, w_mnt_b, 3'b000};

  assign w_b_gt = {w_exp_b, w_mnt_b} > {w_exp_a, w_mnt_a};

  assign w_nan_a  = (&w_exp_a) && (|w_mnt_a);
  assign w_nan_b  = (&w_exp_b) && (|w_mnt_b);
  assign w_inf_a  = (&w_exp_a) && !(|w_mnt_a);
  assign w_inf_b  = (&w_exp_b) && !(|w_mnt_b);
  assign w_zero_a = !w_hid_a && !(|w_mnt_a);
  assign w_zero_b = !w_hid_b && !(|w_mnt_b);

  always_comb begin
    w_special = SP_NORMAL;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sign_a ^ w_sign_b))) begin
      w_special = SP_NAN;
    end else if (w_inf_a || w_inf_b) begin
      w_special = SP_INF;
    end else if (w_zero_a && w_zero_b) begin
      w_special = SP_ZERO;
    end
  end

  // ---------------- Handshake ----------------
  logic r1_valid, r2_valid;
  logic w_s1_adv, w_s2_adv;

  assign w_s2_adv   = !r2_valid || i_out_ready;
  assign w_s1_adv   = !r1_valid || w_s2_adv;
  assign o_in_ready = w_s1_adv;

  // ---------------- Stage 1 registers ----------------
  logic               r1_sign_l, r1_sign_s, r1_swapped;
  logic [E_WIDTH-1:0] r1_exp_l, r1_exp_diff;
  logic [W-1:0]       r1_mnt_l, r1_mnt_s;
  logic [1:0]         r1_special;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r1_valid    <= 1'b0;
      r1_sign_l   <= 1'b0;
      r1_sign_s   <= 1'b0;
      r1_swapped  <= 1'b0;
      r1_exp_l    <= '0;
      r1_exp_diff <= '0;
      r1_mnt_l    <= '0;
      r1_mnt_s    <= '0;
      r1_special  <= SP_NORMAL;
    end else if (w_s1_adv) begin
      r1_valid <= i_in_valid;
      if (i_in_valid) begin
        r1_swapped  <= w_b_gt;
        r1_special  <= w_special;
        r1_sign_l   <= w_b_gt ? w_sign_b : w_sign_a;
        r1_sign_s   <= w_b_gt ? w_sign_a : w_sign_b;
        r1_exp_l    <= w_b_gt ? w_eexp_b : w_eexp_a;
        r1_exp_diff <= w_b_gt ? (w_eexp_b - w_eexp_a) : (w_eexp_a - w_eexp_b);
        r1_mnt_l    <= w_b_gt ? w_sig_b : w_sig_a;
        r1_mnt_s    <= w_b_gt ? w_sig_a : w_sig_b;
      end
    end
  end

  // ---------------- Stage 2 alignment shifter ----------------
  logic         w_big_shift, w_sticky;
  logic [W-1:0] w_mask, w_shifted, w_aligned;

  assign w_big_shift = 32'(r1_exp_diff) >= (W - 1);
  assign w_mask      = ~({W{1'b1}} << r1_exp_diff);
  assign w_shifted   = r1_mnt_s >> r1_exp_diff;
  assign w_sticky    = |(r1_mnt_s & w_mask);

  // Shifts of W-1 or more leave only the sticky bit.
  always_comb begin
    if (w_big_shift) begin
      w_aligned = {{(W-1){1'b0}}, |r1_mnt_s};
    end else begin
      w_aligned = w_shifted | {{(W-1){1'b0}}, w_sticky};
    end
  end

  // ---------------- Stage 2 registers (drive outputs) ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r2_valid   <= 1'b0;
      o_sign_l   <= 1'b0;
      o_sign_s   <= 1'b0;
      o_exp_l    <= '0;
      o_exp_diff <= '0;
      o_mnt_l    <= '0;
      o_mnt_s_al <= '0;
      o_swapped  <= 1'b0;
      o_eff_sub  <= 1'b0;
      o_special  <= SP_NORMAL;
    end else if (w_s2_adv) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        o_sign_l   <= r1_sign_l;
        o_sign_s   <= r1_sign_s;
        o_exp_l    <= r1_exp_l;
        o_exp_diff <= r1_exp_diff;
        o_mnt_l    <= r1_mnt_l;
        o_mnt_s_al <= w_aligned;
        o_swapped  <= r1_swapped;
        o_eff_sub  <= r1_sign_l ^ r1_sign_s;
        o_special  <= r1_special;
      end
    end
  end

  assign o_out_valid = r2_valid;

endmodule

// File: tb/tb_fp_decode_align.sv
// Scoreboard bench for fp_decode_align: directed vectors, backpressure and mid-stream reset.
module tb_fp_decode_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_l, sign_s, swapped, eff_sub;
  logic [7:0]  exp_l, exp_diff;
  logic [26:0] mnt_l, mnt_s_al;
  logic [1:0]  special;

  int n_checks = 0;
  int n_pass   = 0;
  logic [75:0] q_exp[$];

  fp_decode_align #(.E_WIDTH(8), .M_WIDTH(23)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_op_sub    (op_sub),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_sign_l    (sign_l),
    .o_sign_s    (sign_s),
    .o_exp_l     (exp_l),
    .o_exp_diff  (exp_diff),
    .o_mnt_l     (mnt_l),
    .o_mnt_s_al  (mnt_s_al),
    .o_swapped   (swapped),
    .o_eff_sub   (eff_sub),
    .o_special   (special)
  );

  always #5 clk = ~clk;

  logic [75:0] got;
  assign got = {sign_l, sign_s, exp_l, exp_diff, mnt_l, mnt_s_al, swapped, eff_sub, special};

  function automatic logic [75:0] pk(input logic sl, input logic ss, input logic [7:0] el,
                                     input logic [7:0] ed, input logic [26:0] ml,
                                     input logic [26:0] ms, input logic sw, input logic es,
                                     input logic [1:0] sp);
    return {sl, ss, el, ed, ml, ms, sw, es, sp};
  endfunction

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                      input logic [75:0] ve);
    bit done = 0;
    a = va; b = vb; op_sub = vs; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        q_exp.push_back(ve);
        #1;
        done = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 76'd0, 76'd1);
  endtask

  // Monitor: pops and compares whenever a transfer is seen on the output side.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (q_exp.size() == 0) chk("unexpected_output", got, 76'd0);
        else chk("result", got, q_exp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] va[9], vb[9];
  logic        vs[9];
  logic [75:0] ve[9];
  logic [75:0] snap;

  initial begin
    va[0] = 32'h40000000; vb[0] = 32'h3F800000; vs[0] = 0;
    ve[0] = pk(0, 0, 8'h80, 8'h01, 27'h4000000, 27'h2000000, 0, 0, 2'b00);
    va[1] = 32'h3F800000; vb[1] = 32'h40000000; vs[1] = 1;
    ve[1] = pk(1, 0, 8'h80, 8'h01, 27'h4000000, 27'h2000000, 1, 1, 2'b00);
    va[2] = 32'h4B800000; vb[2] = 32'h3F800001; vs[2] = 0;
    ve[2] = pk(0, 0, 8'h97, 8'h18, 27'h4000000, 27'h0000005, 0, 0, 2'b00);
    va[3] = 32'h64000000; vb[3] = 32'h3F800000; vs[3] = 0;
    ve[3] = pk(0, 0, 8'hC8, 8'h49, 27'h4000000, 27'h0000001, 0, 0, 2'b00);
    va[4] = 32'h7F800000; vb[4] = 32'hFF800000; vs[4] = 0;
    ve[4] = pk(0, 1, 8'hFF, 8'h00, 27'h4000000, 27'h4000000, 0, 1, 2'b11);
    va[5] = 32'h7FC00000; vb[5] = 32'h3F800000; vs[5] = 0;
    ve[5] = pk(0, 0, 8'hFF, 8'h80, 27'h6000000, 27'h0000001, 0, 0, 2'b11);
    va[6] = 32'h7F800000; vb[6] = 32'h3F800000; vs[6] = 0;
    ve[6] = pk(0, 0, 8'hFF, 8'h80, 27'h4000000, 27'h0000001, 0, 0, 2'b10);
    va[7] = 32'h00000000; vb[7] = 32'h80000000; vs[7] = 0;
    ve[7] = pk(0, 1, 8'h01, 8'h00, 27'h0000000, 27'h0000000, 0, 1, 2'b01);
    va[8] = 32'h00000001; vb[8] = 32'h00800000; vs[8] = 0;
    ve[8] = pk(0, 0, 8'h01, 8'h00, 27'h4000000, 27'h0000008, 1, 0, 2'b00);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 76'(out_valid), 76'd0);
    chk("reset_in_ready", 76'(in_ready), 76'd1);
    chk("reset_outputs", got, 76'd0);

    // Directed vectors, full throughput.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(va[i], vb[i], vs[i], ve[i]);
    for (int t = 0; t < 20 && q_exp.size() != 0; t++) @(negedge clk);
    chk("drain_directed", 76'(q_exp.size()), 76'd0);

    // Backpressure: four ops against a stalled sink.
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(va[i], vb[i], vs[i], ve[i]);
      end
    join_none
    repeat (6) @(negedge clk);
    chk("bp_in_ready_low", 76'(in_ready), 76'd0);
    chk("bp_out_valid_held", 76'(out_valid), 76'd1);
    chk("bp_head_value", got, ve[0]);
    snap = got;
    repeat (2) @(negedge clk);
    chk("bp_outputs_frozen", got, snap);
    chk("bp_pending_count", 76'(q_exp.size()), 76'd2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_back_to_back", 76'(out_valid), 76'd1);
    end
    wait fork;
    for (int t = 0; t < 20 && q_exp.size() != 0; t++) @(negedge clk);
    chk("drain_backpressure", 76'(q_exp.size()), 76'd0);

    // Mid-stream reset with two ops in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(va[2], vb[2], vs[2], ve[2]);
    send(va[3], vb[3], vs[3], ve[3]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_exp.delete();
    @(negedge clk);
    chk("midrst_out_valid", 76'(out_valid), 76'd0);
    chk("midrst_outputs", got, 76'd0);
    chk("midrst_in_ready", 76'(in_ready), 76'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(va[5], vb[5], vs[5], ve[5]);
    @(negedge clk);
    chk("latency_not_early", 76'(out_valid), 76'd0);
    @(negedge clk);
    chk("latency_two_cycles", 76'(out_valid), 76'd1);
    for (int t = 0; t < 20 && q_exp.size() != 0; t++) @(negedge clk);
    chk("drain_final", 76'(q_exp.size()), 76'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
